// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - command FIFO and pulse sequencer driving a JK flip-flop, with shadow-state checker
module jk_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             cmd_done,
  output logic             mismatch,
  output logic             q_exp,
  output logic [15:0]      issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 + CNT_W;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Command FIFO storage; pointers carry one extra bit to tell full from empty.
  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_j;
  logic             r_k;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_done;
  logic             r_q_exp;
  logic             r_mismatch;
  logic [15:0]      r_issued;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic [1:0]       w_head_op;
  logic [CNT_W-1:0] w_head_cnt;

  logic             w_j_nxt;
  logic             w_k_nxt;
  logic [1:0]       w_op_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [GW-1:0]    w_gap_nxt;
  logic             w_done_nxt;
  logic             w_q_exp_nxt;
  logic             w_issue;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = cmd_valid && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_op  = w_head[EW-1 -: 2];
  assign w_head_cnt = w_head[CNT_W-1:0];

  // Ready is derived only from registered pointers, so a same-cycle pop never
  // reopens the input until the following cycle.
  assign cmd_ready    = !w_full;
  assign busy         = (r_state != S_IDLE) || !w_empty;
  assign j            = r_j;
  assign k            = r_k;
  assign cmd_done     = r_done;
  assign mismatch     = r_mismatch;
  assign q_exp        = r_q_exp;
  assign issued_count = r_issued;

  // FIFO data write; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {cmd_op, cmd_count};
    end
  end

  // FIFO pointer update; reset flushes any queued commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Next-state and datapath decode for the IDLE/DRIVE/GAP sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_op_nxt    = r_op;
    w_rem_nxt   = r_rem;
    w_gap_nxt   = r_gap_cnt;
    w_done_nxt  = 1'b0;
    w_q_exp_nxt = r_q_exp;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_op_nxt             = w_head_op;
          w_rem_nxt            = (w_head_cnt == '0) ? CNT_W'(1) : w_head_cnt;
          {w_j_nxt, w_k_nxt}   = w_head_op;
          w_state_nxt          = S_DRIVE;
        end else begin
          {w_j_nxt, w_k_nxt}   = 2'b00;
        end
      end
      S_DRIVE: begin
        // The flip-flop captures {j,k} on this edge, so the shadow moves with it.
        {w_j_nxt, w_k_nxt} = 2'b00;
        w_rem_nxt          = r_rem - CNT_W'(1);
        w_gap_nxt          = GW'(GAP_CYCLES - 1);
        w_issue            = 1'b1;
        case (r_op)
          2'b01:   w_q_exp_nxt = 1'b0;
          2'b10:   w_q_exp_nxt = 1'b1;
          2'b11:   w_q_exp_nxt = ~r_q_exp;
          default: w_q_exp_nxt = r_q_exp;
        endcase
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt != '0) begin
          w_gap_nxt = r_gap_cnt - GW'(1);
        end else if (r_rem != '0) begin
          {w_j_nxt, w_k_nxt} = r_op;
          w_state_nxt        = S_DRIVE;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        {w_j_nxt, w_k_nxt} = 2'b00;
        w_state_nxt        = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, counters and shadow state; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_j       <= 1'b0;
      r_k       <= 1'b0;
      r_op      <= 2'b00;
      r_rem     <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
      r_q_exp   <= 1'b0;
      r_issued  <= 16'd0;
    end else begin
      r_j       <= w_j_nxt;
      r_k       <= w_k_nxt;
      r_op      <= w_op_nxt;
      r_rem     <= w_rem_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_done    <= w_done_nxt;
      r_q_exp   <= w_q_exp_nxt;
      if (w_issue) r_issued <= r_issued + 16'd1;
    end
  end

  // Sticky divergence flag between fed-back q and the shadow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mismatch <= 1'b0;
    end else if (q_fb != r_q_exp) begin
      r_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - directed self-checking bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             j;
  logic             k;
  logic             q_fb;
  logic             busy;
  logic             cmd_done;
  logic             mismatch;
  logic             q_exp;
  logic [15:0]      issued_count;

  logic             ff_q;
  logic             force_en = 1'b0;
  logic             force_val = 1'b0;

  int errors = 0;
  int checks = 0;

  jk_cmd_sequencer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .j(j),
    .k(k),
    .q_fb(q_fb),
    .busy(busy),
    .cmd_done(cmd_done),
    .mismatch(mismatch),
    .q_exp(q_exp),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  // Behavioural JK flip-flop sharing the DUT reset.
  always @(posedge clk) begin
    if (reset) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = force_en ? force_val : ff_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    force_en  = 1'b0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] jm, km, qm, dm;
    do_reset(3);
    checks++;
    if ({j, k, cmd_ready, busy, cmd_done, mismatch, q_exp} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0010000", {j, k, cmd_ready, busy, cmd_done, mismatch, q_exp});
    end
    checks++;
    if (issued_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_issued: got %0d expected 0", issued_count);
    end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    step();
    cmd_valid = 1'b0;
    jm = '0; km = '0; qm = '0; dm = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      jm[i] = j & ~k; km[i] = k; qm[i] = q_fb; dm[i] = cmd_done;
    end
    checks++;
    if (jm !== 16'h0002) begin errors++; $display("FAIL set1_j_mask: got %h expected 0002", jm); end
    checks++;
    if (km !== 16'h0000) begin errors++; $display("FAIL set1_k_mask: got %h expected 0000", km); end
    checks++;
    if (qm !== 16'h01FC) begin errors++; $display("FAIL set1_q_mask: got %h expected 01fc", qm); end
    checks++;
    if (dm !== 16'h0010) begin errors++; $display("FAIL set1_done_mask: got %h expected 0010", dm); end
    checks++;
    if ({issued_count, q_exp, mismatch} !== {16'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL set1_final: got issued=%0d q_exp=%b mismatch=%b expected 1 1 0", issued_count, q_exp, mismatch);
    end
  endtask

  task automatic test_toggle_burst();
    logic [15:0] tm, qm, dm;
    do_reset(2);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = 4'd3;
    step();
    cmd_valid = 1'b0;
    tm = '0; qm = '0; dm = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      tm[i] = j & k; qm[i] = q_fb; dm[i] = cmd_done;
    end
    checks++;
    if (tm !== 16'h0092) begin errors++; $display("FAIL toggle_pulse_mask: got %h expected 0092", tm); end
    checks++;
    if (qm !== 16'h1F1C) begin errors++; $display("FAIL toggle_q_mask: got %h expected 1f1c", qm); end
    checks++;
    if (dm !== 16'h0400) begin errors++; $display("FAIL toggle_done_mask: got %h expected 0400", dm); end
    checks++;
    if ({issued_count, mismatch} !== {16'd3, 1'b0}) begin
      errors++;
      $display("FAIL toggle_final: got issued=%0d mismatch=%b expected 3 0", issued_count, mismatch);
    end
  endtask

  task automatic test_back_to_back_zero_count();
    logic [15:0] sm, am, dm, em;
    do_reset(2);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd0;
    step();
    sm = '0; am = '0; dm = '0; em = '0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) begin cmd_op = 2'b00; cmd_count = 4'd2; end
      if (i == 2) cmd_valid = 1'b0;
      step();
      sm[i] = j & ~k; am[i] = j | k; dm[i] = cmd_done; em[i] = q_exp;
    end
    checks++;
    if (sm !== 16'h0002) begin errors++; $display("FAIL zero_set_mask: got %h expected 0002", sm); end
    checks++;
    if (am !== 16'h0002) begin errors++; $display("FAIL zero_any_pulse_mask: got %h expected 0002", am); end
    checks++;
    if (dm !== 16'h0810) begin errors++; $display("FAIL zero_done_mask: got %h expected 0810", dm); end
    checks++;
    if (em !== 16'h7FFC) begin errors++; $display("FAIL zero_qexp_mask: got %h expected 7ffc", em); end
    checks++;
    if (issued_count !== 16'd3) begin errors++; $display("FAIL zero_issued: got %0d expected 3", issued_count); end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int rise = -1;
    int dones = 0;
    logic ready_at4 = 1'b1;
    do_reset(2);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd15;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) accepts++;
      step();
      if (cmd_done) dones++;
      if (i == 4) ready_at4 = cmd_ready;
      if (i > 4 && cmd_ready) begin
        rise = i;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (accepts !== 5) begin errors++; $display("FAIL bp_accepts: got %0d expected 5", accepts); end
    checks++;
    if (ready_at4 !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", ready_at4); end
    checks++;
    if (rise !== 47) begin errors++; $display("FAIL bp_ready_rise_cycle: got %0d expected 47", rise); end
    for (int n = 0; n < 400 && busy; n++) begin
      step();
      if (cmd_done) dones++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain_timeout: got busy=%b expected 0", busy); end
    checks++;
    if (dones !== 5) begin errors++; $display("FAIL bp_done_count: got %0d expected 5", dones); end
    checks++;
    if ({issued_count, q_exp, mismatch} !== {16'd75, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_final: got issued=%0d q_exp=%b mismatch=%b expected 75 0 0", issued_count, q_exp, mismatch);
    end
  endtask

  task automatic test_mismatch();
    do_reset(2);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    step();
    cmd_valid = 1'b0;
    repeat (6) step();
    checks++;
    if ({q_exp, mismatch} !== 2'b10) begin errors++; $display("FAIL mm_before: got q_exp,mismatch=%b expected 10", {q_exp, mismatch}); end
    force_en = 1'b1; force_val = 1'b0;
    step();
    force_en = 1'b0;
    checks++;
    if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set: got %b expected 1", mismatch); end
    repeat (3) step();
    checks++;
    if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b expected 1", mismatch); end
    do_reset(1);
    checks++;
    if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_reset_clear: got %b expected 0", mismatch); end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] am, dm, bm, jm;
    do_reset(2);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = 4'd8;
    step();
    cmd_op = 2'b10; cmd_count = 4'd1;
    step();
    cmd_op = 2'b01; cmd_count = 4'd1;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if ({j, k, busy, q_exp} !== 4'b0011) begin errors++; $display("FAIL mid_pre_reset: got j,k,busy,q_exp=%b expected 0011", {j, k, busy, q_exp}); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({j, k, cmd_ready, busy, cmd_done, q_exp} !== 6'b001000) begin
      errors++;
      $display("FAIL mid_after_reset: got %b expected 001000", {j, k, cmd_ready, busy, cmd_done, q_exp});
    end
    checks++;
    if (issued_count !== 16'd0) begin errors++; $display("FAIL mid_issued_reset: got %0d expected 0", issued_count); end
    am = '0; dm = '0; bm = '0;
    for (int i = 1; i <= 6; i++) begin
      step();
      am[i] = j | k; dm[i] = cmd_done; bm[i] = busy;
    end
    checks++;
    if ({am, dm, bm} !== 48'd0) begin errors++; $display("FAIL mid_quiet: got pulse=%h done=%h busy=%h expected all 0", am, dm, bm); end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    step();
    cmd_valid = 1'b0;
    jm = '0; dm = '0;
    for (int i = 1; i <= 6; i++) begin
      step();
      jm[i] = j & ~k; dm[i] = cmd_done;
    end
    checks++;
    if ({jm, dm} !== {16'h0002, 16'h0010}) begin errors++; $display("FAIL mid_next_cmd: got j=%h done=%h expected 0002 0010", jm, dm); end
    checks++;
    if ({issued_count, q_exp, mismatch} !== {16'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_next_final: got issued=%0d q_exp=%b mismatch=%b expected 1 1 0", issued_count, q_exp, mismatch);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_toggle_burst();
    test_back_to_back_zero_count();
    test_backpressure();
    test_mismatch();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
